// File: rtl/rxuart.sv
// rxuart: 8N1 UART receiver, 2-flop synchronized input, mid-bit sampling.
// Ports: i_clk, i_rst_n (sync, active low), i_uart_rx -> o_data, o_valid, o_frame_err, o_busy.
module rxuart #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int CNT_WIDTH       = $clog2(CLOCKS_PER_BAUD)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HALF =
    CNT_WIDTH'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] FULL =
    CNT_WIDTH'(CLOCKS_PER_BAUD - 1);

  logic                 r_sync1;
  logic                 r_rx_s;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_idx;
  logic [7:0]           r_shift;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_ferr;

  state_t               w_state_nx;
  logic [CNT_WIDTH-1:0] w_cnt_nx;
  logic [2:0]           w_idx_nx;
  logic [7:0]           w_shift_nx;
  logic [7:0]           w_data_nx;
  logic                 w_valid_nx;
  logic                 w_ferr_nx;
  logic                 w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_uart_rx;
      r_rx_s  <= r_sync1;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_ferr_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nx = S_START;
          w_cnt_nx   = HALF;
        end
      end
      S_START: begin
        if (!w_cnt_zero) begin
          w_cnt_nx = r_cnt - CNT_WIDTH'(1);
        end else if (r_rx_s) begin
          // line went back high before mid-start: glitch
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DATA;
          w_cnt_nx   = FULL;
          w_idx_nx   = '0;
        end
      end
      S_DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nx = r_cnt - CNT_WIDTH'(1);
        end else begin
          w_shift_nx[r_idx] = r_rx_s;
          w_cnt_nx          = FULL;
          w_idx_nx          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nx = r_cnt - CNT_WIDTH'(1);
        end else if (r_rx_s) begin
          // leave at mid-stop so a new start bit can follow at once
          w_data_nx  = r_shift;
          w_valid_nx = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_ferr_nx  = 1'b1;
          w_state_nx = S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_rx_s) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rxuart.sv
// tb_rxuart: scoreboard bench for rxuart at 16 clocks per bit.
// Frames are driven on negedges; outputs are sampled on negedges.
module tb_rxuart;

  localparam int CPB = 16;
  localparam int LAT = 155;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  rxuart #(.CLOCKS_PER_BAUD(CPB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         nvalid = 0;
  int         npush = 0;
  int         nferr = 0;
  int         ferr_t = -1;
  logic [7:0] last_good = 8'h00;
  logic       prev_v = 1'b0;
  logic       prev_f = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    int e;
    e = cyc;
    if (stop_bit) begin
      q.push_back('{b, e + LAT});
      npush++;
      last_good = b;
    end else begin
      ferr_t = e + LAT;
    end
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_bit);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ferr"}, o_frame_err, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      nvalid++;
      chk("valid_excl", o_frame_err, 0);
      chk("valid_width", prev_v, 0);
      chk("busy_at_valid", o_busy, 0);
      if (q.size() == 0) begin
        chk("valid_unexpected", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("data", o_data, e.d);
        chk("valid_time", cyc, e.t);
      end
    end
    if (o_frame_err) begin
      nferr++;
      chk("ferr_width", prev_f, 0);
      chk("ferr_time", cyc, ferr_t);
      ferr_t = -1;
    end
    prev_v = o_valid;
    prev_f = o_frame_err;
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);

    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", o_busy, 1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", o_busy, 0);
    chk("glitch_data", o_data, last_good);

    send_frame(8'hFF, 1'b0);
    repeat (40) @(negedge clk);
    chk("brk_busy_hi", o_busy, 1);
    chk("brk_data", o_data, last_good);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_busy_lo", o_busy, 0);
    repeat (16) @(negedge clk);
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge clk);

    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("midrst");
    last_good = 8'h00;
    repeat (32) @(negedge clk);
    chk("midrst_idle", o_busy, 0);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
    repeat (200) @(negedge clk);

    chk("pending", q.size(), 0);
    chk("valid_count", nvalid, npush);
    chk("ferr_count", nferr, 1);
    chk("final_data", o_data, 8'hFF);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
